mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// LL/SC link tracking with snoop invalidation, and a memory-wait watchdog.
module mc_control_unit #(
    parameter int WAIT_MAX = 255,
    parameter bit LLSC_EN  = 1'b1,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [31:0]       instr,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic              alu_zero,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoopaddr,
    output logic              icuREN,
    output logic              dcuREN,
    output logic              dcuWEN,
    output logic              regwr,
    output logic              ir_en,
    output logic              pc_en,
    output logic [1:0]        pc_src,
    output logic [1:0]        regdst,
    output logic              memtoreg,
    output logic              sc_result,
    output logic              halt,
    output logic              mem_err,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LL    = 6'b110000;
    localparam logic [5:0] OP_SC    = 6'b111000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Counter only needs to reach WAIT_MAX-1 before the watchdog halts the core.
    localparam int              CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam bit              WD_ON    = (WAIT_MAX > 0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WAIT_MAX - 1);

    state_t              state_r;
    state_t              next_s;
    logic [31:0]         ir_r;
    logic [CNT_W-1:0]    wd_cnt_r;
    logic                mem_err_r;
    logic                sc_result_r;
    logic                link_valid_r;
    logic [ADDR_W-1:0]   link_addr_r;
    logic                waiting_s;
    logic                wd_fire_s;

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic       is_rtype_s, is_jr_s, is_lw_s, is_sw_s, is_ll_s, is_sc_s;
    logic       is_beq_s, is_bne_s, is_j_s, is_jal_s, is_halt_s, taken_s;
    logic       link_hit_s, snoop_hit_s, sc_ok_s, sc_leave_s, ll_set_s;
    logic       unused_ir_s;

    assign op_s       = ir_r[31:26];
    assign funct_s    = ir_r[5:0];
    assign unused_ir_s = ^ir_r[25:6];

    assign is_rtype_s = (op_s == OP_RTYPE);
    assign is_jr_s    = is_rtype_s && (funct_s == FN_JR);
    assign is_lw_s    = (op_s == OP_LW);
    assign is_sw_s    = (op_s == OP_SW);
    assign is_ll_s    = (op_s == OP_LL);
    assign is_sc_s    = (op_s == OP_SC);
    assign is_beq_s   = (op_s == OP_BEQ);
    assign is_bne_s   = (op_s == OP_BNE);
    assign is_j_s     = (op_s == OP_J);
    assign is_jal_s   = (op_s == OP_JAL);
    assign is_halt_s  = (op_s == OP_HALT);
    assign taken_s    = (is_beq_s && alu_zero) || (is_bne_s && !alu_zero);

    // A snoop hitting the link in the very cycle SC evaluates makes the SC fail.
    assign link_hit_s  = link_valid_r && (link_addr_r == dmemaddr);
    assign snoop_hit_s = snoop_inv && (snoopaddr == link_addr_r);
    assign sc_ok_s     = LLSC_EN ? (link_hit_s && !snoop_hit_s) : 1'b1;
    assign sc_leave_s  = (state_r == ST_MEM) && is_sc_s && (next_s == ST_WB);
    assign ll_set_s    = LLSC_EN && (state_r == ST_MEM) && is_ll_s && dhit;

    assign state     = state_r;
    assign mem_err   = mem_err_r;
    assign sc_result = sc_result_r;

    // Next-state and Moore outputs; only ir_en and pc_en are qualified by hits.
    always_comb begin
        next_s    = state_r;
        icuREN    = 1'b0;
        dcuREN    = 1'b0;
        dcuWEN    = 1'b0;
        regwr     = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 2'b00;
        regdst    = 2'b00;
        memtoreg  = 1'b0;
        halt      = 1'b0;
        waiting_s = 1'b0;
        wd_fire_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                icuREN = 1'b1;
                if (ihit) begin
                    ir_en  = 1'b1;
                    next_s = ST_DECODE;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_halt_s) begin
                    next_s = ST_HALT;
                end else begin
                    next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_beq_s || is_bne_s) begin
                    pc_en  = 1'b1;
                    pc_src = taken_s ? 2'b01 : 2'b00;
                    next_s = ST_FETCH;
                end else if (is_j_s) begin
                    pc_en  = 1'b1;
                    pc_src = 2'b10;
                    next_s = ST_FETCH;
                end else if (is_jr_s) begin
                    pc_en  = 1'b1;
                    pc_src = 2'b11;
                    next_s = ST_FETCH;
                end else if (is_lw_s || is_sw_s || is_ll_s || is_sc_s) begin
                    next_s = ST_MEM;
                end else begin
                    next_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (is_lw_s || is_ll_s) begin
                    dcuREN = 1'b1;
                    if (dhit) begin
                        next_s = ST_WB;
                    end else begin
                        waiting_s = 1'b1;
                    end
                end else if (is_sw_s) begin
                    dcuWEN = 1'b1;
                    if (dhit) begin
                        pc_en  = 1'b1;
                        next_s = ST_FETCH;
                    end else begin
                        waiting_s = 1'b1;
                    end
                end else if (is_sc_s) begin
                    if (sc_ok_s) begin
                        dcuWEN = 1'b1;
                        if (dhit) begin
                            next_s = ST_WB;
                        end else begin
                            waiting_s = 1'b1;
                        end
                    end else begin
                        next_s = ST_WB;
                    end
                end else begin
                    next_s = ST_FETCH;
                end
            end
            ST_WB: begin
                regwr    = 1'b1;
                pc_en    = 1'b1;
                memtoreg = is_lw_s || is_ll_s;
                if (is_rtype_s) begin
                    regdst = 2'b01;
                end else if (is_jal_s) begin
                    regdst = 2'b10;
                    pc_src = 2'b10;
                end else begin
                    regdst = 2'b00;
                end
                next_s = ST_FETCH;
            end
            ST_HALT: begin
                halt   = 1'b1;
                next_s = ST_HALT;
            end
            default: begin
                next_s = ST_HALT;
            end
        endcase
        if (WD_ON && waiting_s && (wd_cnt_r == WD_LIMIT)) begin
            wd_fire_s = 1'b1;
            next_s    = ST_HALT;
        end else begin
            wd_fire_s = 1'b0;
        end
    end

    // State register, instruction register and watchdog
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ST_FETCH;
            ir_r      <= 32'd0;
            wd_cnt_r  <= {CNT_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            state_r <= next_s;
            if (ir_en) begin
                ir_r <= instr;
            end
            if (next_s != state_r) begin
                wd_cnt_r <= {CNT_W{1'b0}};
            end else if (waiting_s) begin
                wd_cnt_r <= wd_cnt_r + CNT_W'(1);
            end
            if (wd_fire_s) begin
                mem_err_r <= 1'b1;
            end
        end
    end

    // Link register: an LL completing beats a coincident snoop invalidate
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_r <= 1'b0;
            link_addr_r  <= {ADDR_W{1'b0}};
        end else if (ll_set_s) begin
            link_valid_r <= 1'b1;
            link_addr_r  <= dmemaddr;
        end else if (sc_leave_s || snoop_hit_s) begin
            link_valid_r <= 1'b0;
        end
    end

    // SC outcome captured as it leaves MEM and held for write-back
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sc_result_r <= 1'b0;
        end else if (sc_leave_s) begin
            sc_result_r <= sc_ok_s;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: full output vector compared per step
// against hand-derived values, with a short watchdog limit.
module tb_mc_control_unit;

    logic        CLK;
    logic        nRST;
    logic [31:0] instr;
    logic        ihit;
    logic        dhit;
    logic [31:0] dmemaddr;
    logic        alu_zero;
    logic        snoop_inv;
    logic [31:0] snoopaddr;
    logic        icuREN, dcuREN, dcuWEN, regwr, ir_en, pc_en;
    logic [1:0]  pc_src, regdst;
    logic        memtoreg, sc_result, halt, mem_err;
    logic [2:0]  state;

    int n_cmp;
    int n_err;

    localparam logic [31:0] I_ADD  = 32'h0109_5020;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_LL   = 32'hC000_0000;
    localparam logic [31:0] I_SC   = 32'hE000_0000;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_BNE  = 32'h1400_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_JR   = 32'h0000_0008;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    mc_control_unit #(
        .WAIT_MAX (4),
        .LLSC_EN  (1'b1),
        .ADDR_W   (32)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .instr     (instr),
        .ihit      (ihit),
        .dhit      (dhit),
        .dmemaddr  (dmemaddr),
        .alu_zero  (alu_zero),
        .snoop_inv (snoop_inv),
        .snoopaddr (snoopaddr),
        .icuREN    (icuREN),
        .dcuREN    (dcuREN),
        .dcuWEN    (dcuWEN),
        .regwr     (regwr),
        .ir_en     (ir_en),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .sc_result (sc_result),
        .halt      (halt),
        .mem_err   (mem_err),
        .state     (state)
    );

    logic [16:0] obs;
    assign obs = {icuREN, dcuREN, dcuWEN, regwr, ir_en, pc_en, pc_src, regdst,
                  memtoreg, sc_result, halt, mem_err, state};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [16:0] ev(input int icu, input int dre, input int dwe,
                                       input int rw, input int ire, input int pce,
                                       input int pcs, input int rd, input int m2r,
                                       input int sc, input int hl, input int me,
                                       input int st);
        return {icu[0], dre[0], dwe[0], rw[0], ire[0], pce[0], pcs[1:0], rd[1:0],
                m2r[0], sc[0], hl[0], me[0], st[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [16:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Fetch ins with ihit, then advance n-1 more cycles; IR must hold ins.
    task automatic fetch_to(input logic [31:0] ins, input int n);
        instr = ins;
        ihit  = 1'b1;
        tick();
        ihit  = 1'b0;
        instr = I_HALT;
        for (int i = 1; i < n; i++) tick();
    endtask

    task automatic do_ll(input int sc);
        fetch_to(I_LL, 3);
        dmemaddr = 32'h0000_0100;
        dhit = 1'b1;
        #1;
        chk("ll_mem", ev(0,1,0,0,0,0,0,0,0,sc,0,0,3));
        tick();
        dhit = 1'b0;
        #1;
        chk("ll_wb", ev(0,0,0,1,0,1,0,0,1,sc,0,0,4));
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nRST = 1'b0; instr = 32'd0; ihit = 1'b0; dhit = 1'b0;
        dmemaddr = 32'd0; alu_zero = 1'b0; snoop_inv = 1'b0; snoopaddr = 32'd0;
        #2;
        chk("reset", ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
        #10;
        nRST = 1'b1;
        tick();

        // ADD: 0,1,2,4,0
        instr = I_ADD; ihit = 1'b1;
        #1;
        chk("add_fetch", ev(1,0,0,0,1,0,0,0,0,0,0,0,0));
        tick();
        ihit = 1'b0; instr = I_HALT;
        #1;
        chk("add_decode", ev(0,0,0,0,0,0,0,0,0,0,0,0,1));
        tick();
        chk("add_exec", ev(0,0,0,0,0,0,0,0,0,0,0,0,2));
        tick();
        chk("add_wb", ev(0,0,0,1,0,1,0,1,0,0,0,0,4));
        tick();

        // LW with dhit on the third MEM cycle
        fetch_to(I_LW, 3);
        for (int k = 0; k < 3; k++) begin
            dhit = (k == 2);
            #1;
            chk("lw_mem", ev(0,1,0,0,0,0,0,0,0,0,0,0,3));
            tick();
        end
        dhit = 1'b0;
        #1;
        chk("lw_wb", ev(0,0,0,1,0,1,0,0,1,0,0,0,4));
        tick();

        // LL/SC success; snoop on another address must not break the link
        do_ll(0);
        instr = I_SC; ihit = 1'b1;
        tick();
        ihit = 1'b0; instr = I_HALT; snoop_inv = 1'b1; snoopaddr = 32'h0000_0200;
        tick();
        snoop_inv = 1'b0;
        tick();
        dmemaddr = 32'h0000_0100; dhit = 1'b0;
        #1;
        chk("sc_mem_wait", ev(0,0,1,0,0,0,0,0,0,0,0,0,3));
        tick();
        dhit = 1'b1;
        #1;
        chk("sc_mem_hit", ev(0,0,1,0,0,0,0,0,0,0,0,0,3));
        tick();
        dhit = 1'b0;
        #1;
        chk("sc_wb", ev(0,0,0,1,0,1,0,0,0,1,0,0,4));
        tick();

        // LL, snoop on the linked address before SC: SC fails
        do_ll(1);
        instr = I_SC; ihit = 1'b1;
        tick();
        ihit = 1'b0; instr = I_HALT; snoop_inv = 1'b1; snoopaddr = 32'h0000_0100;
        tick();
        snoop_inv = 1'b0;
        tick();
        #1;
        chk("scf_mem", ev(0,0,0,0,0,0,0,0,0,1,0,0,3));
        tick();
        chk("scf_wb", ev(0,0,0,1,0,1,0,0,0,0,0,0,4));
        tick();

        // Snoop in the same cycle SC evaluates forces failure
        do_ll(0);
        fetch_to(I_SC, 3);
        snoop_inv = 1'b1; snoopaddr = 32'h0000_0100; dhit = 1'b1;
        #1;
        chk("scs_mem", ev(0,0,0,0,0,0,0,0,0,0,0,0,3));
        tick();
        snoop_inv = 1'b0; dhit = 1'b0;
        #1;
        chk("scs_wb", ev(0,0,0,1,0,1,0,0,0,0,0,0,4));
        tick();

        // Branches, jumps
        fetch_to(I_BEQ, 2);
        alu_zero = 1'b1;
        #1;
        chk("beq_exec", ev(0,0,0,0,0,1,1,0,0,0,0,0,2));
        tick();
        chk("beq_next", ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
        fetch_to(I_BNE, 2);
        #1;
        chk("bne_exec", ev(0,0,0,0,0,1,0,0,0,0,0,0,2));
        tick();
        alu_zero = 1'b0;
        fetch_to(I_JAL, 2);
        #1;
        chk("jal_exec", ev(0,0,0,0,0,0,0,0,0,0,0,0,2));
        tick();
        chk("jal_wb", ev(0,0,0,1,0,1,2,2,0,0,0,0,4));
        tick();
        fetch_to(I_JR, 2);
        #1;
        chk("jr_exec", ev(0,0,0,0,0,1,3,0,0,0,0,0,2));
        tick();

        // SW completing on first MEM cycle
        fetch_to(I_SW, 3);
        dhit = 1'b1;
        #1;
        chk("sw_mem", ev(0,0,1,0,0,1,0,0,0,0,0,0,3));
        tick();
        dhit = 1'b0;
        #1;
        chk("sw_done", ev(1,0,0,0,0,0,0,0,0,0,0,0,0));

        // Reset asserted mid-MEM takes effect immediately
        fetch_to(I_SW, 3);
        #1;
        chk("sw_wait", ev(0,0,1,0,0,0,0,0,0,0,0,0,3));
        nRST = 1'b0;
        #1;
        chk("rst_mid_mem", ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        nRST = 1'b1;

        // Watchdog: ihit low for 4 FETCH cycles
        tick();
        tick();
        tick();
        chk("wd_pre", ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
        tick();
        chk("wd_fire", ev(0,0,0,0,0,0,0,0,0,0,1,1,5));
        ihit = 1'b1;
        tick();
        chk("halt_hold", ev(0,0,0,0,0,0,0,0,0,0,1,1,5));
        ihit = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rst_clear", ev(1,0,0,0,0,0,0,0,0,0,0,0,0));
        #1;
        nRST = 1'b1;
        tick();

        // HALT opcode
        fetch_to(I_HALT, 2);
        #1;
        chk("halt_op", ev(0,0,0,0,0,0,0,0,0,0,1,0,5));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
